// File: rtl/s3g_pkg.sv
// Shared definitions for the S3G host-port receive path.
package s3g_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBrk   = 3'd4
    } uart_rx_state_e;

    localparam int unsigned S3G_DEFAULT_DIVISOR = 868;  // 100 MHz / 115200 baud

    localparam logic [7:0] S3G_SYNC_BYTE = 8'hD5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; INIT is the reset/idle level.
module sync_2ff #(
    parameter bit INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/s3g_uart_rx.sv
// 8N1 UART receiver: one rx_done strobe per well-framed byte, one rx_frame_err per bad stop bit.
module s3g_uart_rx
    import s3g_pkg::*;
#(
    parameter int unsigned DIVISOR = S3G_DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned HALF = DIVISOR / 2;
    localparam int unsigned CntW = $clog2(DIVISOR);

    localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DIVISOR - 1);

    logic rx_s;

    sync_2ff #(
        .INIT (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_rx_state_e  state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            done_q;
    logic            ferr_q;

    // cnt_q restarts on every transition and on every data-bit sample, so bit k is
    // taken exactly DIVISOR cycles after bit k-1 regardless of counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            cnt_q  <= cnt_q + CntW'(1);
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= StBrk;
                        end
                    end
                end
                StBrk: begin
                    // Hold off until the line returns high so a break yields a single error.
                    if (rx_s) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data      = data_q;
    assign rx_done      = done_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_s3g_uart_rx.sv
// Directed bench for s3g_uart_rx at DIVISOR=16: vector table plus corner-case sequences.
module tb_s3g_uart_rx;

    localparam int unsigned Div = 16;
    // Pin-to-strobe latency: 2 sync flops + half bit + 9 bits + registered strobe.
    localparam int Lat = 2 + Div / 2 + 9 * Div + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    s3g_uart_rx #(
        .DIVISOR (Div)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    int cyc      = 0;
    bit rst_edge = 1'b1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    int         done_cnt      = 0;
    int         err_cnt       = 0;
    int         both_cnt      = 0;
    int         stab_cnt      = 0;
    int         last_done_cyc = 0;
    logic [7:0] prev_data     = 8'h00;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (rx_frame_err) err_cnt++;
        if (rx_done && rx_frame_err) both_cnt++;
        if (rx_data !== prev_data && !rx_done && !rst_edge) stab_cnt++;
        prev_data = rx_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         stop;
        int         exp_done;
        int         exp_err;
        bit         chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    int         d0;
    int         e0;
    int         start_cyc;
    logic [7:0] b2b[5];

    initial begin
        vecs[0] = '{8'hD5, 16, 1'b1, 1, 0, 1'b1, 8'hD5};
        vecs[1] = '{8'h81, 17, 1'b1, 1, 0, 1'b1, 8'h81};
        // 15-cycle bits drift past bit 6 before the end of the frame; only framing is required.
        vecs[2] = '{8'h81, 15, 1'b1, 1, 0, 1'b0, 8'h00};
        vecs[3] = '{8'h00, 16, 1'b1, 1, 0, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 16, 1'b1, 1, 0, 1'b1, 8'hFF};
        vecs[5] = '{8'h7E, 16, 1'b0, 0, 1, 1'b1, 8'hFF};
        vecs[6] = '{8'h3C, 16, 1'b1, 1, 0, 1'b1, 8'h3C};
        vecs[7] = '{8'hD5, 16, 1'b1, 1, 0, 1'b1, 8'hD5};
        b2b     = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03};

        rst = 1'b1;
        idle(3);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_done", rx_done, 1'b0);
        check("reset rx_frame_err", rx_frame_err, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        idle(4);
        check("idle rx_busy", rx_busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d0        = done_cnt;
            e0        = err_cnt;
            start_cyc = cyc;
            send_frame(vecs[i].data, vecs[i].period, vecs[i].stop);
            rx = 1'b1;
            idle(24);
            check($sformatf("v%0d done count", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d err count", i), err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].chk_data) check($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
            if (vecs[i].exp_done == 1)
                check($sformatf("v%0d latency", i), last_done_cyc - start_cyc, Lat);
            check($sformatf("v%0d busy after", i), rx_busy, 1'b0);
        end

        // Short low glitch: start bit rejected at the half-bit sample.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(1);
        check("glitch busy high", rx_busy, 1'b1);
        idle(15);
        check("glitch busy low", rx_busy, 1'b0);
        check("glitch done count", done_cnt - d0, 0);
        check("glitch err count", err_cnt - e0, 0);
        check("glitch rx_data", rx_data, 8'hD5);

        // Bad stop bit followed by a long break, then recovery.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 16, 1'b0);
        idle(200);
        check("break err count", err_cnt - e0, 1);
        check("break done count", done_cnt - d0, 0);
        check("break rx_data", rx_data, 8'hD5);
        check("break busy", rx_busy, 1'b1);
        rx = 1'b1;
        idle(8);
        check("break released", rx_busy, 1'b0);
        d0 = done_cnt;
        send_frame(8'h3C, 16, 1'b1);
        rx = 1'b1;
        idle(24);
        check("after break done", done_cnt - d0, 1);
        check("after break rx_data", rx_data, 8'h3C);

        // Back-to-back frames with no idle gap.
        got_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_frame(b2b[i], 16, 1'b1);
        rx = 1'b1;
        idle(24);
        check("b2b done count", done_cnt - d0, 5);
        check("b2b err count", err_cnt - e0, 0);
        check("b2b queue size", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check($sformatf("b2b byte %0d", i), got_q[i], b2b[i]);
        end

        // 18-cycle bits exceed the tolerance; reported only.
        d0 = done_cnt;
        send_frame(8'h81, 18, 1'b1);
        rx = 1'b1;
        idle(24);
        $display("note: 18-cycle bit period is out of range: %0d strobe(s), rx_data=%02h",
                 done_cnt - d0, rx_data);

        // Reset during data bit 4 of 0xFF, then a clean 0x55.
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        idle(Div);
        rx = 1'b1;
        idle(4 * Div + Div / 2);
        check("pre-reset busy", rx_busy, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("post-reset busy", rx_busy, 1'b0);
        check("post-reset rx_data", rx_data, 8'h00);
        idle(6 * Div);
        start_cyc = cyc;
        send_frame(8'h55, 16, 1'b1);
        rx = 1'b1;
        idle(24);
        check("abort done count", done_cnt - d0, 1);
        check("abort err count", err_cnt - e0, 0);
        check("abort rx_data", rx_data, 8'h55);
        check("abort latency", last_done_cyc - start_cyc, Lat);

        check("done with err same cycle", both_cnt, 0);
        check("rx_data changed without strobe", stab_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
